traffic_input_cond: RTL and testbench

//  Input conditioning stage directly upstream of the traffic-light controller.

---
 rtl/traffic_pkg.sv | 14 +
 rtl/in_debounce.sv | 40 ++++
 rtl/traffic_input_cond.sv | 76 +++++++
 tb/tb_traffic_input_cond.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its input stage.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } light_t;

  localparam int DEB_CYCLES_DEF  = 4;
  localparam int HOLD_CYCLES_DEF = 8;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/in_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw input.
module in_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  logic             s1_reg;
  logic             s2_reg;
  logic             deb_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg  <= 1'b0;
      s2_reg  <= 1'b0;
      deb_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      // the counter only advances on an unbroken run of disagreement
      if (s2_reg == deb_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
        deb_reg <= s2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign deb = deb_reg;

endmodule

// File: rtl/traffic_input_cond.sv
// Conditions raw sensors and buttons into stretched traffic flags and
// single-cycle parade/release pulses for the traffic-light FSMs.
module traffic_input_cond
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sa_raw,
  input  logic sb_raw,
  input  logic p_btn,
  input  logic r_btn,
  output logic ta,
  output logic tb,
  output logic p,
  output logic r
);

  logic [3:0] raw_vec;
  logic [3:0] deb_vec;
  logic [1:0] stretch;
  logic [1:0] btn_d_reg;

  assign raw_vec = {r_btn, p_btn, sb_raw, sa_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      in_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_vec[gi]),
        .deb  (deb_vec[gi])
      );
    end

    for (gi = 0; gi < 2; gi++) begin : g_stretch
      logic [CNT_W-1:0] hold_reg;

      // Reloading while deb is high means the edge on which deb falls leaves
      // hold at HOLD_CYCLES; while deb is high the OR below masks hold anyway.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_reg <= '0;
        end else if (deb_vec[gi]) begin
          hold_reg <= CNT_W'(HOLD_CYCLES);
        end else if (hold_reg != '0) begin
          hold_reg <= hold_reg - 1'b1;
        end
      end

      assign stretch[gi] = deb_vec[gi] | (hold_reg != '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_d_reg <= '0;
    end else begin
      btn_d_reg <= deb_vec[3:2];
    end
  end

  assign ta = stretch[0];
  assign tb = stretch[1];
  // release outranks parade when both rise together
  assign r  = deb_vec[3] & ~btn_d_reg[1];
  assign p  = deb_vec[2] & ~btn_d_reg[0] & ~r;

endmodule

// File: tb/tb_traffic_input_cond.sv
// Randomised and directed check of traffic_input_cond against a window-based model.
module tb_traffic_input_cond;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sa_raw = 1'b0, sb_raw = 1'b0, p_btn = 1'b0, r_btn = 1'b0;
  logic ta, tb, p, r;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_ta, n_tb, n_p, n_r;

  // model state: synchroniser delay, sample window, debounced values, time since fall
  logic [3:0] m_s1, m_s2, m_deb;
  bit         win[4][$];
  int         since_fall[2];
  logic       exp_ta, exp_tb, exp_p, exp_r;

  traffic_input_cond #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sa_raw(sa_raw),
    .sb_raw(sb_raw),
    .p_btn (p_btn),
    .r_btn (r_btn),
    .ta    (ta),
    .tb    (tb),
    .p     (p),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_deb = '0;
    for (int i = 0; i < 4; i++) win[i].delete();
    since_fall[0] = HOLD;
    since_fall[1] = HOLD;
    exp_ta = 1'b0; exp_tb = 1'b0; exp_p = 1'b0; exp_r = 1'b0;
  endtask

  // A debounced value flips once the last DEB synchronised samples all disagree with it.
  task automatic model_edge(input logic [3:0] rv);
    logic [3:0] old_deb;
    bit flip;
    old_deb = m_deb;
    for (int i = 0; i < 4; i++) begin
      win[i].push_back(m_s2[i]);
      if (win[i].size() > DEB) void'(win[i].pop_front());
      flip = (win[i].size() == DEB);
      for (int k = 0; k < win[i].size(); k++)
        if (win[i][k] == old_deb[i]) flip = 0;
      if (flip) m_deb[i] = ~old_deb[i];
    end
    m_s2 = m_s1;
    m_s1 = rv;
    for (int i = 0; i < 2; i++) begin
      if (old_deb[i] && !m_deb[i]) since_fall[i] = 0;
      else if (!m_deb[i] && since_fall[i] < HOLD) since_fall[i]++;
    end
    exp_ta = m_deb[0] | (since_fall[0] < HOLD);
    exp_tb = m_deb[1] | (since_fall[1] < HOLD);
    exp_r  = m_deb[3] & ~old_deb[3];
    exp_p  = m_deb[2] & ~old_deb[2] & ~exp_r;
  endtask

  task automatic edge_check(input logic [3:0] rv);
    @(posedge clk);
    #1;
    model_edge(rv);
    cyc++;
    $display("cyc=%0d raw=%b ta=%b tb=%b p=%b r=%b", cyc, rv, ta, tb, p, r);
    chk("ta", ta, exp_ta);
    chk("tb", tb, exp_tb);
    chk("p", p, exp_p);
    chk("r", r, exp_r);
    n_ta += int'(ta); n_tb += int'(tb); n_p += int'(p); n_r += int'(r);
  endtask

  task automatic step(input logic [3:0] rv);
    @(negedge clk);
    {r_btn, p_btn, sb_raw, sa_raw} = rv;
    edge_check(rv);
  endtask

  task automatic run_n(input logic [3:0] rv, input int n);
    for (int i = 0; i < n; i++) step(rv);
  endtask

  task automatic clr();
    n_ta = 0; n_tb = 0; n_p = 0; n_r = 0;
  endtask

  // asynchronous reset between edges, then release and take the first edge
  task automatic do_reset(input logic [3:0] rv);
    @(negedge clk);
    {r_btn, p_btn, sb_raw, sa_raw} = rv;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_ta", ta, exp_ta);
    chk("rst_tb", tb, exp_tb);
    chk("rst_p", p, exp_p);
    chk("rst_r", r, exp_r);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_check(rv);
  endtask

  initial begin
    logic [3:0] rv;
    clr();
    model_reset();

    // reset with everything asserted, then latency of the first assertion
    do_reset(4'b1111);
    run_n(4'b1111, 4);
    chk("t1_ta_before", ta, 1'b0);
    step(4'b1111);
    chk("t1_ta_after", ta, 1'b1);
    chk("t1_r_collide", r, 1'b1);
    chk("t1_p_collide", p, 1'b0);

    // a 3-cycle glitch is rejected, a 4-cycle pulse gets through
    do_reset(4'b0000);
    clr(); run_n(4'b0001, 3); run_n(4'b0000, 14);
    chk("glitch3_ta", n_ta, 0);
    clr(); run_n(4'b0001, 4); run_n(4'b0000, 14);
    chk("glitch4_ta", n_ta != 0, 1);
    run_n(4'b0000, 10);

    // stretch: 5 cycles of deb still high plus HOLD cycles of hold
    run_n(4'b0010, 10);
    clr(); run_n(4'b0000, 20);
    chk("stretch_tb_cycles", n_tb, 5 + HOLD);
    // re-assert during hold: no dip
    run_n(4'b0001, 10);
    clr(); run_n(4'b0000, 6); run_n(4'b0001, 10);
    chk("reassert_ta_cycles", n_ta, 16);
    run_n(4'b0000, 20);

    // button held gives one pulse; release and re-press gives another
    clr(); run_n(4'b0100, 20);
    chk("btn_first_p", n_p, 1);
    clr(); run_n(4'b0000, 10); run_n(4'b0100, 20);
    chk("btn_second_p", n_p, 1);
    clr(); run_n(4'b0000, 12);
    chk("btn_release_p", n_p, 0);

    // simultaneous press: release wins, no parade pulse follows
    clr(); run_n(4'b1100, 20);
    chk("collide_r", n_r, 1);
    chk("collide_p", n_p, 0);
    run_n(4'b0000, 10);

    // reset during an active hold (hold at 3)
    run_n(4'b0001, 10);
    run_n(4'b0000, 11);
    chk("midop_ta_pre", ta, 1'b1);
    do_reset(4'b0000);
    clr(); run_n(4'b0000, 20);
    chk("midop_ta_after", n_ta, 0);

    // random traffic with sticky inputs and occasional reset
    rv = 4'b0000;
    for (int i = 0; i < 700; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(5) == 0) rv[c] = ~rv[c];
      if ($urandom_range(149) == 0) do_reset(rv);
      else step(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
